// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: sequencing FSM, main/ALU decoders, condition check and NZCV flags.
// Optional CTRL_STALL_EN adds a mem_ready handshake that stalls FETCH, MEMRD and MEMWR.
module multicycle_controller #(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CTRL_STALL_EN
    input  logic              mem_ready,
`endif
    input  logic [3:0]        cond,
    input  logic [1:0]        op,
    input  logic [5:0]        funct,
    input  logic [3:0]        rd,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              pc_write,
    output logic              adr_src,
    output logic              mem_write,
    output logic              ir_write,
    output logic [1:0]        result_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_control,
    output logic [1:0]        imm_src,
    output logic [1:0]        reg_src,
    output logic              reg_write,
    output logic [3:0]        state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    state_e            state_q, state_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              cex_s, mem_rdy_s;
    logic [1:0]        alu_op_s;
    logic              is_cmp_s, cmd_ok_s, arith_s;
    logic              pc_write_s, ir_write_s, mem_write_s, reg_write_s;

`ifdef CTRL_STALL_EN
    assign mem_rdy_s = mem_ready;
`else
    assign mem_rdy_s = 1'b1;
`endif

    function automatic logic cond_check(input logic [3:0] c, input logic n, input logic z,
                                        input logic cy, input logic v);
        case (c)
            4'b0000: cond_check = z;
            4'b0001: cond_check = ~z;
            4'b0010: cond_check = cy;
            4'b0011: cond_check = ~cy;
            4'b0100: cond_check = n;
            4'b0101: cond_check = ~n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = ~v;
            4'b1000: cond_check = cy & ~z;
            4'b1001: cond_check = ~cy | z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = ~z & (n == v);
            4'b1101: cond_check = z | (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    assign cex_s = cond_check(cond, flags_q[FLAG_W-1], flags_q[FLAG_W-2],
                              flags_q[FLAG_W-3], flags_q[FLAG_W-4]);

    // ALU decoder: operation, compare marker, and whether C/V are meaningful
    always_comb begin
        alu_op_s = 2'b00;
        is_cmp_s = 1'b0;
        cmd_ok_s = 1'b1;
        arith_s  = 1'b1;
        case (funct[4:1])
            4'b0100: alu_op_s = 2'b00;
            4'b0010: alu_op_s = 2'b01;
            4'b0000: begin alu_op_s = 2'b10; arith_s = 1'b0; end
            4'b1100: begin alu_op_s = 2'b11; arith_s = 1'b0; end
            4'b1010: begin alu_op_s = 2'b01; is_cmp_s = 1'b1; end
            default: begin alu_op_s = 2'b00; cmd_ok_s = 1'b0; arith_s = 1'b0; end
        endcase
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d     = S_FETCH;
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_s = mem_rdy_s;
                pc_write_s = mem_rdy_s;
                state_d    = mem_rdy_s ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                state_d = mem_rdy_s ? S_MEMWB : S_MEMRD;
            end
            S_MEMWR: begin
                adr_src     = 1'b1;
                mem_write_s = cex_s & mem_rdy_s;
                state_d     = mem_rdy_s ? S_FETCH : S_MEMWR;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                if (rd == 4'd15) begin
                    pc_write_s = cex_s;
                end else begin
                    reg_write_s = cex_s;
                end
            end
            S_EXECR: begin
                alu_control = alu_op_s;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b   = 2'b01;
                alu_control = alu_op_s;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                // compares and unsupported commands never write a destination, PC included
                if (rd == 4'd15) begin
                    pc_write_s = cex_s & cmd_ok_s & ~is_cmp_s;
                end else begin
                    reg_write_s = cex_s & cmd_ok_s & ~is_cmp_s;
                end
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_s = cex_s;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Flag update on leaving an execute state; logic ops keep C and V
    always_comb begin
        flags_d = flags_q;
        if (((state_q == S_EXECR) || (state_q == S_EXECI)) && funct[0] && cex_s) begin
            flags_d[FLAG_W-1] = alu_flags[FLAG_W-1];
            flags_d[FLAG_W-2] = alu_flags[FLAG_W-2];
            if (arith_s) begin
                flags_d[FLAG_W-3] = alu_flags[FLAG_W-3];
                flags_d[FLAG_W-4] = alu_flags[FLAG_W-4];
            end else begin
                flags_d[FLAG_W-3] = flags_q[FLAG_W-3];
                flags_d[FLAG_W-4] = flags_q[FLAG_W-4];
            end
        end else begin
            flags_d = flags_q;
        end
    end

    // State and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Strobes are held off combinationally while reset is asserted
    assign pc_write  = rst & pc_write_s;
    assign ir_write  = rst & ir_write_s;
    assign mem_write = rst & mem_write_s;
    assign reg_write = rst & reg_write_s;
    assign imm_src   = op;
    assign reg_src   = {(op == 2'b01), (op == 2'b10)};
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: per-cycle expected controls queued, then compared.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
`ifdef CTRL_STALL_EN
    logic       mem_ready;
`endif
    logic       pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write;
    logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
    logic [3:0] state_o;

    multicycle_controller #(.FLAG_W(4)) dut (
        .clk(clk), .rst(rst),
`ifdef CTRL_STALL_EN
        .mem_ready(mem_ready),
`endif
        .cond(cond), .op(op), .funct(funct), .rd(rd), .alu_flags(alu_flags),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .reg_src(reg_src),
        .reg_write(reg_write), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       pcw, irw, mw, rw, adr, srca;
        logic [1:0] rsrc, srcb, aluc, imm, rsel;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input logic [3:0] st, input logic pcw, input logic irw, input logic mw,
                        input logic rw, input logic adr, input logic srca, input logic [1:0] rsrc,
                        input logic [1:0] srcb, input logic [1:0] aluc);
        exp_t e;
        e.st = st; e.pcw = pcw; e.irw = irw; e.mw = mw; e.rw = rw; e.adr = adr;
        e.srca = srca; e.rsrc = rsrc; e.srcb = srcb; e.aluc = aluc;
        e.imm  = op;
        e.rsel = {(op == 2'b01), (op == 2'b10)};
        sb.push_back(e);
    endtask

    task automatic e_rst();             push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0); endtask
    task automatic e_fetch();           push(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0); endtask
    task automatic e_decode();          push(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0); endtask
    task automatic e_memadr();          push(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0); endtask
    task automatic e_memrd();           push(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0); endtask
    task automatic e_memwb(input logic rw, input logic pcw);
        push(4'd4, pcw, 1'b0, 1'b0, rw, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0);
    endtask
    task automatic e_memwr(input logic mw);
        push(4'd5, 1'b0, 1'b0, mw, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
    endtask
    task automatic e_exec(input logic imm, input logic [1:0] aluc);
        push(imm ? 4'd7 : 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, imm ? 2'd1 : 2'd0, aluc);
    endtask
    task automatic e_aluwb(input logic rw, input logic pcw);
        push(4'd8, pcw, 1'b0, 1'b0, rw, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    endtask
    task automatic e_branch(input logic pcw);
        push(4'd9, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] ex);
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, ex);
        end
    endtask

    // Sample 2 time units after the negedge, well clear of the rising edge
    task automatic smp();
        exp_t e;
        #2;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty t=%0t observed=%0d expected=entry", $time, sb.size());
        end else begin
            e = sb.pop_front();
            chk("state",       state_o,                e.st);
            chk("pc_write",    {3'b000, pc_write},     {3'b000, e.pcw});
            chk("ir_write",    {3'b000, ir_write},     {3'b000, e.irw});
            chk("mem_write",   {3'b000, mem_write},    {3'b000, e.mw});
            chk("reg_write",   {3'b000, reg_write},    {3'b000, e.rw});
            chk("adr_src",     {3'b000, adr_src},      {3'b000, e.adr});
            chk("alu_src_a",   {3'b000, alu_src_a},    {3'b000, e.srca});
            chk("result_src",  {2'b00, result_src},    {2'b00, e.rsrc});
            chk("alu_src_b",   {2'b00, alu_src_b},     {2'b00, e.srcb});
            chk("alu_control", {2'b00, alu_control},   {2'b00, e.aluc});
            chk("imm_src",     {2'b00, imm_src},       {2'b00, e.imm});
            chk("reg_src",     {2'b00, reg_src},       {2'b00, e.rsel});
        end
    endtask

    task automatic cyc();
        smp();
        @(negedge clk);
    endtask

    task automatic drain();
        while (sb.size() > 0) cyc();
    endtask

    task automatic dp(input logic [3:0] c, input logic [5:0] f, input logic [3:0] r,
                      input logic [3:0] fl, input logic [1:0] aluc, input logic rw, input logic pcw);
        cond = c; op = 2'b00; funct = f; rd = r; alu_flags = fl;
        e_fetch(); e_decode(); e_exec(f[5], aluc); e_aluwb(rw, pcw);
        drain();
    endtask

    task automatic br(input logic [3:0] c, input logic pcw);
        cond = c; op = 2'b10; funct = 6'b100000; rd = 4'd0; alu_flags = 4'b0000;
        e_fetch(); e_decode(); e_branch(pcw);
        drain();
    endtask

    task automatic ldr(input logic [3:0] c, input logic [3:0] r, input logic rw, input logic pcw);
        cond = c; op = 2'b01; funct = 6'b011001; rd = r; alu_flags = 4'b0000;
        e_fetch(); e_decode(); e_memadr(); e_memrd(); e_memwb(rw, pcw);
        drain();
    endtask

    task automatic str(input logic [3:0] c, input logic mw);
        cond = c; op = 2'b01; funct = 6'b011000; rd = 4'd3; alu_flags = 4'b0000;
        e_fetch(); e_decode(); e_memadr(); e_memwr(mw);
        drain();
    endtask

    initial begin
        rst = 1'b0; cond = 4'b1110; op = 2'b00; funct = 6'b101001; rd = 4'd1; alu_flags = 4'b0100;
`ifdef CTRL_STALL_EN
        mem_ready = 1'b1;
`endif
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e_rst();
            cyc();
        end
        rst = 1'b1;

        // ADDS immediate, then prove Z was captured
        dp(4'b1110, 6'b101001, 4'd1, 4'b0100, 2'b00, 1'b1, 1'b0);
        br(4'b0000, 1'b1);
        // CMP sets Z: BEQ taken; CMP clears Z: BEQ not taken
        dp(4'b1110, 6'b010101, 4'd0, 4'b0100, 2'b01, 1'b0, 1'b0);
        br(4'b0000, 1'b1);
        dp(4'b1110, 6'b010101, 4'd0, 4'b0000, 2'b01, 1'b0, 1'b0);
        br(4'b0000, 1'b0);
        // ANDS loads N,Z but keeps C,V (both 0)
        dp(4'b1110, 6'b000001, 4'd1, 4'b1011, 2'b10, 1'b1, 1'b0);
        br(4'b0100, 1'b1);
        br(4'b0010, 1'b0);
        br(4'b0110, 1'b0);
        // SUBS immediate: flags 0011 -> LT taken, GE not, HI taken
        dp(4'b1110, 6'b100101, 4'd2, 4'b0011, 2'b01, 1'b1, 1'b0);
        br(4'b1011, 1'b1);
        br(4'b1010, 1'b0);
        br(4'b1000, 1'b1);
        // ORR to R15 writes PC; unsupported cmd writes nothing; ORR without S keeps flags
        dp(4'b1110, 6'b011000, 4'd15, 4'b1111, 2'b11, 1'b0, 1'b1);
        dp(4'b1110, 6'b000010, 4'd4, 4'b1111, 2'b00, 1'b0, 1'b0);
        br(4'b1011, 1'b1);
        // failed condition blocks both the write and the flag update
        dp(4'b0000, 6'b101001, 4'd5, 4'b0100, 2'b00, 1'b0, 1'b0);
        br(4'b0000, 1'b0);
        // undefined op: FETCH, DECODE, FETCH
        cond = 4'b1110; op = 2'b11; funct = 6'b000000; rd = 4'd0;
        e_fetch(); e_decode();
        drain();
        // loads: to R15 redirect PC, otherwise write the register file
        ldr(4'b1110, 4'd15, 1'b0, 1'b1);
        ldr(4'b1110, 4'd2, 1'b1, 1'b0);
        // STRNE with Z=1 suppressed; STR AL writes
        dp(4'b1110, 6'b010101, 4'd0, 4'b0100, 2'b01, 1'b0, 1'b0);
        str(4'b0001, 1'b0);
        str(4'b1110, 1'b1);
        // reset mid-store: strobe drops at once, flags cleared (Z was 1)
        cond = 4'b1110; op = 2'b01; funct = 6'b011000; rd = 4'd3;
        e_fetch(); e_decode(); e_memadr();
        cyc(); cyc(); cyc();
        e_memwr(1'b1);
        smp();
        rst = 1'b0;
        e_rst();
        smp();
        @(negedge clk);
        e_rst();
        cyc();
        rst = 1'b1;
        br(4'b0000, 1'b0);
        br(4'b0001, 1'b1);
`ifdef CTRL_STALL_EN
        // stalled fetch: no strobes until mem_ready, then a single pulse
        cond = 4'b1110; op = 2'b11; funct = 6'b000000; rd = 4'd0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e_rst();
            cyc();
        end
        mem_ready = 1'b1;
        e_fetch(); e_decode();
        drain();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Sequencing controller for the multicycle variant of the ARM-subset processor. It replaces single-cycle control with an FSM that drives a shared-memory datapath: one memory port for instructions and data, one ALU reused for PC increment and branch-target calculation. It also contains the main decoder, the ALU decoder, the condition-check logic and the NZCV flag register. All write strobes are gated by the instruction's condition field.

Parameters:
FLAG_W, 4, width of the flag register and of alu_flags (N,Z,C,V from MSB to LSB)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-low; forces state and flags to reset values immediately
cond  input  4  instruction bits [31:28]
op  input  2  instruction bits [27:26]
funct  input  6  instruction bits [25:20]; I = [5], cmd = [4:1], S/L = [0]
rd  input  4  instruction bits [15:12]
alu_flags  input  FLAG_W  NZCV result of the current ALU operation
pc_write  output  1  PC register load enable
adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register
mem_write  output  1  data memory write strobe
ir_write  output  1  instruction register load enable
result_src  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALU direct
alu_src_a  output  1  ALU A select: 0 = RD1 register, 1 = PC
alu_src_b  output  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4
alu_control  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR
imm_src  output  2  extend unit select; equals op
reg_src  output  2  [0] = 1 when op=10 (RA1 = R15); [1] = 1 when op=01 (RA2 = Rd)
reg_write  output  1  register file write enable
state_o  output  4  current FSM state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10-15 return to FETCH on the next clock and assert no strobes.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by op: op=00 with I=0 -> EXECR; op=00 with I=1 -> EXECI; op=01 -> MEMADR; op=10 -> BRANCH; op=11 -> FETCH (undefined instruction, no side effects).
  - MEMADR -> MEMRD if L=1, else MEMWR.
  - MEMRD -> MEMWB -> FETCH. MEMWR -> FETCH.
  - EXECR and EXECI -> ALUWB -> FETCH. BRANCH -> FETCH.
- Per-state outputs (anything not listed is 0; alu_control = ADD unless stated):
  - FETCH: adr_src=0, ir_write=1, alu_src_a=1, alu_src_b=10, result_src=10, pc_write=1.
  - DECODE: alu_src_a=1, alu_src_b=10, result_src=10 (R15 reads PC+8).
  - MEMADR: alu_src_a=0, alu_src_b=01.
  - MEMRD: adr_src=1.
  - MEMWR: adr_src=1, mem_write=cex.
  - MEMWB: result_src=01, reg_write=cex.
  - EXECR: alu_src_b=00, alu_control from cmd.
  - EXECI: alu_src_b=01, alu_control from cmd.
  - ALUWB: result_src=00, reg_write=cex AND NOT cmp.
  - BRANCH: alu_src_a=0, alu_src_b=01, result_src=10, pc_write=cex.
- ALU decoder (cmd): 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR, 1010 -> SUB with cmp=1. Any other cmd -> ADD and suppresses reg_write.
- Writes to R15: in MEMWB or ALUWB with rd=15, pc_write=cex and reg_write=0.
- Condition check (cex, combinational from cond and the flag register):
  - 0000 EQ = Z, 0001 NE = !Z, 0010 CS = C, 0011 CC = !C.
  - 0100 MI = N, 0101 PL = !N, 0110 VS = V, 0111 VC = !V.
  - 1000 HI = C & !Z, 1001 LS = !C | Z.
  - 1010 GE = N==V, 1011 LT = N!=V, 1100 GT = !Z & N==V, 1101 LE = Z | N!=V.
  - 1110 AL = 1, 1111 = 0.
- Flag register update: on the clock edge leaving EXECR or EXECI, when S=1 and cex=1.
  - N and Z are always loaded.
  - C and V are loaded only for ADD, SUB and CMP; they hold for AND and ORR.
- Flags change only at that edge, so cex is stable for the whole instruction.
- Reset:
  - While rst=0: state=FETCH and flags=0000.
  - All strobes (pc_write, ir_write, mem_write, reg_write) are forced to 0; mux selects take their FETCH values.
  - Reset asserted mid-instruction aborts it with no further writes. The first FETCH strobes appear in the first cycle after rst deasserts.
- Latency in cycles, counting FETCH: data-processing 4, LDR 5, STR 4, B 3, undefined 2.

Optional Feature:
CTRL_STALL_EN
- Defined: adds input mem_ready (1 bit).
  - In FETCH, MEMRD and MEMWR the FSM holds state while mem_ready=0.
  - ir_write, pc_write and mem_write are asserted only in the cycle where mem_ready=1.
  - Mux selects stay stable throughout the stall.
- Not defined: the port is absent and memory is treated as single-cycle (mem_ready effectively 1).

Test Plan:
1. rst low 3 cycles then high; op=00, funct=101001 (ADDS imm), cond=1110, alu_flags=0100 -> states 0,1,7,8,0; pc_write=1 in FETCH only; reg_write=1 in ALUWB; flags=0100 after EXECI.
2. CMP (funct=010101) with alu_flags=0100, then BEQ (op=10, cond=0000) -> no reg_write in ALUWB; BEQ asserts pc_write=1 in BRANCH. Repeat with alu_flags=0000 -> pc_write=0 in BRANCH.
3. LDR (op=01, funct=011001, rd=15) -> states 0,1,2,3,4; adr_src=1 in MEMRD; in MEMWB reg_write=0 and pc_write=1.
4. STR (op=01, L=0) with cond=0001 while Z=1 -> MEMWR reached with mem_write=0; returns to FETCH.
5. rst pulled low during MEMWR of an AL store -> mem_write drops immediately; state=0; flags=0000.
6. CTRL_STALL_EN build, mem_ready=0 for 3 cycles in FETCH -> state stays 0; ir_write and pc_write stay 0 until mem_ready=1, then both pulse for exactly 1 cycle.
